// File: rtl/mult_ctrl_if.sv
// Handshake/bus bundle between the mult_ctrl sequencer, its requester and the iterative multiplier.
// slave = sequencer view; master = requester/multiplier view.
interface mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_mult;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] mult_multiplicand;
    logic [WIDTH-1:0] mult_multiplier;
    logic [31:0]      mult_count;
    logic [WIDTH-1:0] mult_product;
    logic             mult_overflow;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport slave (
        input  ctrl_mult, data_operandA, data_operandB, mult_product, mult_overflow,
        output mult_multiplicand, mult_multiplier, mult_count,
               data_result, data_exception, data_resultRDY, busy
    );

    modport master (
        output ctrl_mult, data_operandA, data_operandB, mult_product, mult_overflow,
        input  mult_multiplicand, mult_multiplier, mult_count,
               data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/mult_ctrl.sv
// Sequencer around the iterative multiplier: latches operands on start, steps the count, captures the product.
// Result pulses ready MULT_CYCLES edges after start; a new start at any time aborts and restarts (no backpressure).
module mult_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 17
) (
    input  logic       clock,
    input  logic       reset,
    mult_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LAST_COUNT = 32'(MULT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [31:0]      count_q, count_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        count_d  = count_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        // A start wins over everything, including the capture edge.
        if (bus.ctrl_mult) begin
            mcand_d  = bus.data_operandA;
            mplier_d = bus.data_operandB;
            count_d  = 32'd0;
            state_d  = RUN;
        end else if (state_q == RUN) begin
            if (count_q == LAST_COUNT) begin
                result_d = bus.mult_product;
                exc_d    = bus.mult_overflow;
                rdy_d    = 1'b1;
                state_d  = DONE;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            count_q  <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            count_q  <= count_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.mult_multiplicand = mcand_q;
    assign bus.mult_multiplier   = mplier_q;
    assign bus.mult_count        = count_q;
    assign bus.data_result       = result_q;
    assign bus.data_exception    = exc_q;
    assign bus.data_resultRDY    = rdy_q;
    assign bus.busy              = busy_q;
endmodule
